// File: rtl/tpuv1_host_seq.sv
// tpuv1_host_seq: bus-master that clears C, loads A/B rows, triggers compute and streams C back
module tpuv1_host_seq #(
   parameter int DIM          = 8,
   parameter int ADDRW        = 16,
   parameter int DATAW        = 64,
   parameter int COMPUTE_WAIT = DIM * 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear_c,
   output logic             busy,
   output logic             done,
   input  logic [DATAW-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [DATAW-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ADDRW-1:0] tpu_addr,
   output logic [DATAW-1:0] tpu_dataIn,
   output logic             tpu_r_w,
   input  logic [DATAW-1:0] tpu_dataOut
);
   localparam int NW = 2 * DIM;
   localparam int KW = $clog2(NW) + 1;
   localparam int WW = COMPUTE_WAIT > 1 ? $clog2(COMPUTE_WAIT) : 1;
   localparam logic [ADDRW-1:0] A_BASE = ADDRW'(16'h100);
   localparam logic [ADDRW-1:0] B_BASE = ADDRW'(16'h200);
   localparam logic [ADDRW-1:0] C_BASE = ADDRW'(16'h300);
   localparam logic [ADDRW-1:0] T_ADDR = ADDRW'(16'h400);

   typedef enum logic [2:0] {IDLE, CLR_C, LOAD, TRIG, WAIT, READ, DONE} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WW-1:0]    w_q, w_d;
   logic             busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
   logic [DATAW-1:0] out_data_q, out_data_d;
   logic             last_k, issue, take;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      w_d         = w_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      tpu_r_w     = 1'b0;
      tpu_addr    = '0;
      tpu_dataIn  = '0;
      last_k      = k_q == KW'(NW - 1);
      take        = out_valid_q && out_ready;
      // k reaches NW once every C word has been issued; the register then only drains
      issue       = state_q == READ && k_q != KW'(NW) && (!out_valid_q || out_ready);
      in_ready    = state_q == LOAD;
      case (state_q)
         IDLE: if (start) begin
            state_d = clear_c ? CLR_C : LOAD;
            k_d     = '0;
         end
         CLR_C: begin
            tpu_r_w  = 1'b1;
            tpu_addr = C_BASE + (ADDRW'(k_q) << 3);
            k_d      = last_k ? '0 : k_q + 1'b1;
            state_d  = last_k ? LOAD : CLR_C;
         end
         LOAD: if (in_valid) begin
            tpu_r_w    = 1'b1;
            tpu_dataIn = in_data;
            tpu_addr   = (k_q[0] ? B_BASE : A_BASE) + (ADDRW'(k_q >> 1) << 3);
            k_d        = last_k ? '0 : k_q + 1'b1;
            state_d    = last_k ? TRIG : LOAD;
         end
         TRIG: begin
            tpu_r_w  = 1'b1;
            tpu_addr = T_ADDR;
            w_d      = '0;
            state_d  = WAIT;
         end
         WAIT: begin
            w_d = w_q + 1'b1;
            if (w_q == WW'(COMPUTE_WAIT - 1)) begin
               state_d = READ;
               k_d     = '0;
            end
         end
         READ: begin
            tpu_addr = C_BASE + (ADDRW'(k_q) << 3);
            if (issue) begin
               out_data_d  = tpu_dataOut;
               out_valid_d = 1'b1;
               k_d         = k_q + 1'b1;
            end else if (take) begin
               out_valid_d = 1'b0;
               state_d     = k_q == KW'(NW) ? DONE : READ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
      done_d = state_d == DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         w_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         w_q         <= w_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
endmodule

// File: tb/tb_tpuv1_host_seq.sv
// tb_tpuv1_host_seq: job table plus reset sequences against an accumulating tpuv1 memory model
module tb_tpuv1_host_seq;
   localparam int NW = 16;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear_c = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [63:0] in_data = '0;
   logic [63:0] out_data, tpu_dataIn, tpu_dataOut;
   logic        busy, done, in_ready, out_valid, tpu_r_w;
   logic [15:0] tpu_addr;

   int nvec = 0, nmis = 0;
   logic [63:0]       mem [0:255];
   logic [15:0][63:0] cmodel = '0;
   logic [7:0][63:0]  ta, tbm;
   logic [15:0][63:0] tcm;

   typedef struct {
      bit clr;
      bit tog;
      bit stall;
      bit spam;
      bit ident;
      int exp_done;
   } job_t;
   job_t jobs [6];

   always #5 clk = ~clk;

   tpuv1_host_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear_c(clear_c), .busy(busy), .done(done),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn), .tpu_r_w(tpu_r_w), .tpu_dataOut(tpu_dataOut)
   );

   // C += A*B with signed 8-bit A/B lanes and wrapping 16-bit C lanes
   function automatic logic [15:0][63:0] mac(input logic [7:0][63:0] a, input logic [7:0][63:0] b,
                                            input logic [15:0][63:0] c);
      logic [15:0][63:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < 8; k++) s += $signed(a[i][8*k+:8]) * $signed(b[k][8*j+:8]);
            r[2*i+j/4][16*(j%4)+:16] = r[2*i+j/4][16*(j%4)+:16] + 16'(s);
         end
      return r;
   endfunction

   assign tpu_dataOut = mem[tpu_addr[10:3]];

   always @(posedge clk) begin
      if (tpu_r_w) begin
         if (tpu_addr == 16'h400) begin
            for (int i = 0; i < 8; i++) begin
               ta[i]  = mem[32+i];
               tbm[i] = mem[64+i];
            end
            for (int i = 0; i < 16; i++) tcm[i] = mem[96+i];
            tcm = mac(ta, tbm, tcm);
            for (int i = 0; i < 16; i++) mem[96+i] <= tcm[i];
         end else mem[tpu_addr[10:3]] <= tpu_dataIn;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_data"}, out_data, 64'd0);
      chk({tag, "_tpu_addr"}, 64'(tpu_addr), 64'd0);
      chk({tag, "_tpu_r_w"}, 64'(tpu_r_w), 64'd0);
      chk({tag, "_tpu_dataIn"}, tpu_dataIn, 64'd0);
   endtask

   task automatic run_job(input job_t j);
      logic [63:0]       w [NW];
      logic [7:0][63:0]  a, b;
      logic [15:0][63:0] exp_c;
      logic [15:0]       ea[$], wa[$];
      logic [63:0]       ed[$], wd[$], got[$];
      int idx = 0, done_n = -1, stall_left = 0, pulses = 0, nmin;
      bit stalled = 0;
      for (int r = 0; r < 8; r++) begin
         w[2*r]   = j.ident ? 64'h1 << (8 * r) : {$urandom, $urandom};
         w[2*r+1] = j.ident ? {8{8'(r + 1)}} : {$urandom, $urandom};
         a[r] = w[2*r];
         b[r] = w[2*r+1];
      end
      exp_c = mac(a, b, j.clr ? '0 : cmodel);
      if (j.clr) for (int i = 0; i < NW; i++) begin
         ea.push_back(16'(16'h300 + 8 * i));
         ed.push_back('0);
      end
      for (int i = 0; i < NW; i++) begin
         ea.push_back(16'((i % 2 ? 16'h200 : 16'h100) + 8 * (i / 2)));
         ed.push_back(w[i]);
      end
      ea.push_back(16'h400);
      ed.push_back('0);
      for (int n = 0; n < 400; n++) begin
         start    = (n == 0) || (j.spam && (n == 40 || n == 55));
         clear_c  = (n == 0) ? j.clr : 1'b1;
         in_valid = j.tog ? (n % 2 == 1) : 1'b1;
         in_data  = idx < NW ? w[idx] : {$urandom, $urandom};
         if (j.stall && !stalled && out_valid && got.size() == 3) begin
            stalled    = 1;
            stall_left = 10;
         end
         out_ready = stall_left == 0;
         @(negedge clk);
         if (tpu_r_w) begin
            wa.push_back(tpu_addr);
            wd.push_back(tpu_dataIn);
         end
         if (in_valid && in_ready) idx++;
         if (stall_left > 0) begin
            chk("stall_out_data", out_data, exp_c[3]);
            chk("stall_tpu_addr", 64'(tpu_addr), 64'h320);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            stall_left--;
         end
         if (out_valid && out_ready) got.push_back(out_data);
         if (done) begin
            pulses++;
            if (done_n < 0) begin
               done_n = n;
               chk("busy_at_done", 64'(busy), 64'd1);
            end
         end
         if (done_n >= 0 && n == done_n + 1) chk("busy_after_done", 64'(busy), 64'd0);
         @(posedge clk);
         #1;
         if (done_n >= 0 && n == done_n + 4) break;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      chk("done_cycle", 64'(done_n), 64'(j.exp_done));
      chk("done_pulses", 64'(pulses), 64'd1);
      chk("write_count", 64'(wa.size()), 64'(ea.size()));
      nmin = wa.size() < ea.size() ? wa.size() : ea.size();
      for (int i = 0; i < nmin; i++) begin
         chk("write_addr", 64'(wa[i]), 64'(ea[i]));
         chk("write_data", wd[i], ed[i]);
      end
      chk("word_count", 64'(got.size()), 64'(NW));
      for (int i = 0; i < NW && i < got.size(); i++) begin
         chk("c_word", got[i], exp_c[i]);
         if (j.ident) chk("ident_widened_b", got[i], {4{16'(i / 2 + 1)}});
      end
      cmodel = exp_c;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      jobs[0] = '{clr: 1, tog: 0, stall: 0, spam: 0, ident: 0, exp_done: 83};
      jobs[1] = '{clr: 0, tog: 1, stall: 0, spam: 0, ident: 0, exp_done: 82};
      jobs[2] = '{clr: 1, tog: 0, stall: 1, spam: 0, ident: 0, exp_done: 93};
      jobs[3] = '{clr: 1, tog: 0, stall: 0, spam: 0, ident: 1, exp_done: 83};
      jobs[4] = '{clr: 0, tog: 0, stall: 0, spam: 1, ident: 0, exp_done: 67};
      jobs[5] = '{clr: 0, tog: 0, stall: 0, spam: 0, ident: 0, exp_done: 67};
      @(negedge clk);
      chk_zero_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) run_job(jobs[i]);
      // abort a job after five LOAD words
      start    = 1'b1;
      clear_c  = 1'b0;
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_data = {$urandom, $urandom};
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("abort");
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_write", 64'(tpu_r_w), 64'd0);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_after_abort", 64'(busy), 64'd0);
      run_job(jobs[0]);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/tpuv1_host_seq.md
# tpuv1_host_seq

Bus-master sequencer driving the tpuv1 memory-mapped port (address, write data, read/write strobe, read data) that the integration bench drives by hand today. Given a start pulse, it optionally zeroes C, streams 2*DIM A/B row words from an input valid/ready stream into A/B space, writes the compute trigger, waits a fixed compute interval, then reads all C words back and emits them on an output valid/ready stream. It sits between the host/DMA side and tpuv1 in the AFU.

## Interface
- DIM, 8, systolic array dimension (rows of A, B, C)
- ADDRW, 16, tpuv1 address width
- DATAW, 64, tpuv1 data width (8 x 8-bit A/B lanes, 4 x 16-bit C lanes)
- COMPUTE_WAIT, 32 (DIM*4), cycles idled after trigger before C readback
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- clear_c  in  1  sampled with start; 1 = zero C before loading
- busy  out  1  high from the cycle after accepted start through the done cycle
- done  out  1  one-cycle pulse when the job completes
- in_data  in  DATAW  A/B row word, order A0,B0,A1,B1,...,A(DIM-1),B(DIM-1)
- in_valid  in  1  in_data valid
- in_ready  out  1  high only in LOAD
- out_data  out  DATAW  C word, order C0lo,C0hi,C1lo,...,C(DIM-1)hi
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- tpu_addr  out  ADDRW  tpuv1 addr
- tpu_dataIn  out  DATAW  tpuv1 dataIn
- tpu_r_w  out  1  tpuv1 r_w (1 = write)
- tpu_dataOut  in  DATAW  tpuv1 dataOut; combinational from tpu_addr with tpu_r_w=0

## Operation
- Address map: A row r at 0x100+8r; B row r at 0x200+8r; C word i (i=0..2*DIM-1) at 0x300+8i (lo = even i, hi = odd i); compute trigger = write to 0x400.
- States: IDLE, CLR_C, LOAD, TRIG, WAIT, READ, DONE. One word counter k (0..2*DIM-1), one wait counter.
- IDLE: tpu_addr=0, tpu_r_w=0, tpu_dataIn=0. start=1 -> CLR_C if clear_c else LOAD; k=0.
- CLR_C: each cycle write 0 to 0x300+8k; after k=2*DIM-1 -> LOAD, k=0.
- LOAD: in_ready=1. Cycle with in_valid=1: tpu_r_w=1, tpu_dataIn=in_data, tpu_addr = 0x100+8*(k/2) for even k, 0x200+8*(k/2) for odd k; k++. in_valid=0: tpu_r_w=0, tpu_addr=0, k holds. After k=2*DIM-1 accepted -> TRIG.
- TRIG: one cycle, tpu_addr=0x400, tpu_r_w=1, tpu_dataIn=0 -> WAIT.
- WAIT: tpu_r_w=0, tpu_addr=0 for exactly COMPUTE_WAIT cycles -> READ, k=0.
- READ: tpu_r_w=0, tpu_addr=0x300+8k. A read is issued when the output register is empty or being emptied this cycle (out_valid & out_ready); at that edge out_data<=tpu_dataOut, out_valid<=1, k++. Otherwise tpu_addr holds and k holds. Output register clears on handshake with no new read. After the last word is issued and handshaken -> DONE.
- DONE: done=1 one cycle, busy=1 -> IDLE.
- start while busy is ignored. in_data outside LOAD is ignored (in_ready=0).
- No arithmetic on data; words pass through unmodified.

## Timing
- Reset (async, immediate): state IDLE, counters 0, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, tpu_addr=0, tpu_r_w=0, tpu_dataIn=0. Reset mid-job aborts; no further bus writes; partial C contents undefined.
- All outputs registered except in_ready and tpu_* (decoded from state/counter and in_valid).
- start at edge 0 with clear_c=1, in_valid and out_ready held 1: CLR_C cycles 1-16, LOAD 17-32, TRIG 33, WAIT 34-65, READ issues 66-81, out_valid 67-82, done cycle 83.
- Same with clear_c=0: LOAD 1-16, TRIG 17, WAIT 18-49, READ issues 50-65, done cycle 67.
- out_ready=0 stalls READ with out_data/out_valid stable; no word dropped or duplicated.

## Test plan
- Reset mid-LOAD (after 5 words) -> all outputs 0 next sample, busy=0; new start runs a full job correctly.
- clear_c=1, random signed A/B from afu_tc, streams unstalled -> exactly 16 zero writes 0x300..0x378, 16 A/B writes in order, one write to 0x400, done at cycle 83; 16 out words match expected C.
- clear_c=0 with in_valid toggling 1/0 every cycle -> no write on in_valid=0 cycles, addresses 0x100,0x200,0x108,... in order, done at cycle 82.
- out_ready held 0 for 10 cycles at word 3 -> out_data constant, tpu_addr stays 0x320, completion delayed exactly 10 cycles, all 16 words correct.
- A = identity, B rows = 1..8 -> out words equal B widened to 16-bit lanes.
- start pulsed during WAIT and READ -> ignored; exactly one done pulse, busy deasserted the cycle after done.
